// File: rtl/tdm_mux4.sv
// Four-channel round-robin TDM multiplexer: one holding register per channel,
// drained in fixed slot order 0..3 onto a tagged output lane. `TDM_PARITY_EN adds out_par.
module tdm_mux4 #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  IDLE_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [1:0]           out_sel,
  output logic                 out_sof
`ifdef TDM_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  logic [1:0]       cnt_q, cnt_d;
  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] hold_q [4];
  logic [WIDTH-1:0] hold_d [4];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_sof_q, out_sof_d;

  // A full channel frees up only on the edge that drains it, so it may reload then.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_ready[k] = ~full_q[k] | (en & (cnt_q == 2'(k)));
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    full_d      = full_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sel_d   = out_sel_q;
    out_sof_d   = 1'b0;

    if (en) begin
      out_sel_d = cnt_q;
      out_sof_d = (cnt_q == 2'd0);
      if (full_q[cnt_q]) begin
        out_data_d     = hold_q[cnt_q];
        out_valid_d    = 1'b1;
        full_d[cnt_q]  = 1'b0;
      end else begin
        out_data_d     = IDLE_WORD;
      end
      cnt_d = cnt_q + 2'd1;
    end

    // Loads come after the drain so a same-edge reload keeps the channel full.
    for (int k = 0; k < 4; k++) begin
      if (in_valid[k] && in_ready[k]) begin
        hold_d[k] = in_data[k*WIDTH +: WIDTH];
        full_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      full_q      <= 4'b0000;
      for (int k = 0; k < 4; k++) hold_q[k] <= '0;
      out_data_q  <= IDLE_WORD;
      out_valid_q <= 1'b0;
      out_sel_q   <= 2'd0;
      out_sof_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_sof   = out_sof_q;

`ifdef TDM_PARITY_EN
  logic out_par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par_q <= ^IDLE_WORD;
    else        out_par_q <= ^out_data_d;
  end
  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_tdm_mux4.sv
// Scoreboard bench for tdm_mux4: per-channel word queues model the mux, a negedge
// monitor compares every output cycle against the expected queue.
module tb_tdm_mux4;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] IDLE = '0;
  localparam int W = WIDTH + 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [4*WIDTH-1:0] in_data = '0;
  logic [3:0]         in_valid = '0;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [1:0]         out_sel;
  logic               out_sof;
`ifdef TDM_PARITY_EN
  logic               out_par;
`endif

  tdm_mux4 #(.WIDTH(WIDTH), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel), .out_sof(out_sof)
`ifdef TDM_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Expected entry: {valid, sof, sel[1:0], data}
  logic [W-1:0]     exp_q[$];
  logic [WIDTH-1:0] ch_q [4][$];
  int               m_slot;
  logic [1:0]       last_sel;
  logic [WIDTH-1:0] last_data;
  logic [W-1:0]     mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("out_lane", {20'd0, out_valid, out_sof, out_sel, out_data}, {20'd0, mon_e});
`ifdef TDM_PARITY_EN
      check("out_par", {31'd0, out_par}, {31'd0, ^mon_e[WIDTH-1:0]});
`endif
    end
  end

  // Drive one cycle, check in_ready against the model, then predict the edge.
  task automatic step(input logic e_i, input logic [3:0] v, input logic [4*WIDTH-1:0] d,
                      output logic [3:0] acc);
    logic [3:0] rdy;
    logic [1:0] sl;
    @(negedge clk);
    en = e_i; in_valid = v; in_data = d;
    #1;
    for (int k = 0; k < 4; k++) rdy[k] = (ch_q[k].size() == 0) || (e_i && m_slot == k);
    check("in_ready", {28'd0, in_ready}, {28'd0, rdy});
    if (e_i) begin
      sl = 2'(m_slot);
      if (ch_q[m_slot].size() > 0) begin
        last_data = ch_q[m_slot].pop_front();
        exp_q.push_back({1'b1, m_slot == 0, sl, last_data});
      end else begin
        last_data = IDLE;
        exp_q.push_back({1'b0, m_slot == 0, sl, IDLE});
      end
      last_sel = sl;
      m_slot = (m_slot + 1) % 4;
    end else begin
      exp_q.push_back({1'b0, 1'b0, last_sel, last_data});
    end
    acc = v & rdy;
    for (int k = 0; k < 4; k++) if (acc[k]) ch_q[k].push_back(d[k*WIDTH +: WIDTH]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; en = 1'b0; in_valid = '0;
    #1;
    check("rst_out", {20'd0, out_valid, out_sof, out_sel, out_data}, {20'd0, 4'b0000, IDLE});
    check("rst_ready", {28'd0, in_ready}, 32'hF);
`ifdef TDM_PARITY_EN
    check("rst_par", {31'd0, out_par}, {31'd0, ^IDLE});
`endif
    for (int k = 0; k < 4; k++) ch_q[k].delete();
    m_slot = 0; last_sel = 2'd0; last_data = IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {28'd0, in_ready}, 32'hF);
  endtask

  task automatic idle(input int n);
    logic [3:0] a;
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, '0, a);
  endtask

  initial begin
    logic [3:0]       a;
    logic [WIDTH-1:0] word;

    do_reset();

    // Empty frames: idle lane, slot tags 0..3, sof on slot 0
    idle(8);

    // All four channels loaded together at slot 0
    step(1'b1, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, a);
    idle(8);

    // Continuous stream on channel 2
    word = 8'h10;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 4'b0100, {8'h00, word, 16'h0000}, a);
      if (a[2]) word = word + 8'h1;
    end
    idle(8);

    // Freeze with channel 1 holding 8'h55; a new offer must be refused
    while (m_slot != 0) idle(1);
    step(1'b1, 4'b0010, {16'h0, 8'h55, 8'h00}, a);
    step(1'b0, 4'b0000, '0, a);
    step(1'b0, 4'b0010, {16'h0, 8'h66, 8'h00}, a);
    step(1'b0, 4'b0000, '0, a);
    idle(6);

    // Reset mid-frame with every channel full: nothing stale may appear
    while (m_slot != 1) idle(1);
    step(1'b1, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, a);
    idle(1);
    repeat (2) @(negedge clk);
    do_reset();
    idle(8);

    // Parity-relevant word on channel 3
    step(1'b1, 4'b1000, {8'h07, 24'h0}, a);
    idle(6);

    // Random traffic with occasional freezes
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), 32'($urandom), a);
    end
    idle(8);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
